// File: rtl/xor_assert_monitor.sv
// xor_assert_monitor
// Per-channel XOR-based assertion checker. Each channel compares its two
// operands under a shared check mode. A failing sample produces a one-cycle
// fail pulse, bumps a saturating failure counter and escalates a severity
// state OK -> INFO -> WARN -> ERROR. ERROR is sticky until clr or rst.
// err_any flags any channel sitting in ERROR.

module xor_assert_monitor #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 8,
    parameter int WARN_THRESH = 3,
    parameter int ERR_THRESH  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       valid,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    output logic [CHANNELS-1:0]       fail,
    output logic [CHANNELS*CNT_W-1:0] fail_cnt,
    output logic [CHANNELS*2-1:0]     sev,
    output logic                      err_any
);

    // Largest value a counter can hold; thresholds must fit inside it.
    localparam longint unsigned CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;

    // Reject threshold settings that would make the escalation ladder
    // meaningless (WARN must come strictly before ERROR, and both must be
    // reachable by the counter).
    if (WARN_THRESH < 1 || WARN_THRESH >= ERR_THRESH ||
        longint'(ERR_THRESH) > longint'(CNT_LIMIT)) begin : g_bad_params
        $fatal(1, "xor_assert_monitor: illegal thresholds WARN_THRESH=%0d ERR_THRESH=%0d CNT_W=%0d",
               WARN_THRESH, ERR_THRESH, CNT_W);
    end

    typedef enum logic [1:0] {
        SEV_OK    = 2'd0,
        SEV_INFO  = 2'd1,
        SEV_WARN  = 2'd2,
        SEV_ERROR = 2'd3
    } sev_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WARN_LVL = CNT_W'(WARN_THRESH);
    localparam logic [CNT_W-1:0] ERR_LVL  = CNT_W'(ERR_THRESH);

    logic [CHANNELS-1:0] fail_now;
    logic [CHANNELS-1:0] fail_q;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    sev_t                state_q [CHANNELS];
    sev_t                state_d [CHANNELS];

    // Evaluate each channel's check for this cycle; a failure only counts
    // when the channel is actually being sampled.
    always_comb begin
        logic [WIDTH-1:0] diff;
        logic             pass;
        fail_now = '0;
        diff     = '0;
        pass     = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            diff = a[i*WIDTH +: WIDTH] ^ b[i*WIDTH +: WIDTH];
            case (mode)
                2'd0:    pass = |diff;
                2'd1:    pass = ~|diff;
                2'd2:    pass = ^diff;
                default: pass = 1'b1;
            endcase
            fail_now[i] = en & valid[i] & ~pass;
        end
    end

    // Next failure count: clr wins over everything, failures add one and
    // stop at the counter ceiling rather than wrapping.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (fail_now[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Next severity derived from the updated count; ERROR holds until clr.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            if (clr) begin
                state_d[i] = SEV_OK;
            end else if (state_q[i] == SEV_ERROR) begin
                state_d[i] = SEV_ERROR;
            end else if (cnt_d[i] >= ERR_LVL) begin
                state_d[i] = SEV_ERROR;
            end else if (cnt_d[i] >= WARN_LVL) begin
                state_d[i] = SEV_WARN;
            end else if (cnt_d[i] != '0) begin
                state_d[i] = SEV_INFO;
            end else begin
                state_d[i] = SEV_OK;
            end
        end
    end

    // Severity state, counters and fail pulse registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= SEV_OK;
                cnt_q[i]   <= '0;
            end
        end else begin
            fail_q <= clr ? '0 : fail_now;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Pack registered per-channel state onto the output buses.
    always_comb begin
        fail     = fail_q;
        fail_cnt = '0;
        sev      = '0;
        err_any  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            fail_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
            sev[i*2 +: 2]              = state_q[i];
            err_any                    = err_any | (state_q[i] == SEV_ERROR);
        end
    end

`ifndef SYNTHESIS
`ifdef XOR_ASSERT_MONITOR_REPORT
    // Announce each severity entry with channel, count and time; only
    // compiled when XOR_ASSERT_MONITOR_REPORT is defined for simulation.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (state_d[i] != state_q[i]) begin
                    case (state_d[i])
                        SEV_INFO: begin
                            if (state_q[i] == SEV_OK)
                                $info("xor_assert_monitor ch%0d INFO count=%0d time=%0t",
                                      i, cnt_d[i], $time);
                        end
                        SEV_WARN:
                            $warning("xor_assert_monitor ch%0d WARN count=%0d time=%0t",
                                     i, cnt_d[i], $time);
                        SEV_ERROR:
                            $error("xor_assert_monitor ch%0d ERROR count=%0d time=%0t",
                                   i, cnt_d[i], $time);
                        default: ;
                    endcase
                end
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_xor_assert_monitor.sv
// tb_xor_assert_monitor
// Directed bench: a table of vectors with hand-computed expectations for the
// default configuration, then hand sequences for escalation to ERROR, the
// asynchronous reset, and saturation/clr priority on a CNT_W=3 instance.

module tb_xor_assert_monitor;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        clr;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;

    logic [3:0]  fail;
    logic [31:0] fail_cnt;
    logic [7:0]  sev;
    logic        err_any;

    logic [3:0]  s_fail;
    logic [11:0] s_fail_cnt;
    logic [7:0]  s_sev;
    logic        s_err_any;

    int checks;
    int errors;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        clr;
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_fail;
        logic [31:0] exp_cnt;
        logic [7:0]  exp_sev;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    xor_assert_monitor #(
        .WIDTH(8), .CHANNELS(4), .CNT_W(8), .WARN_THRESH(3), .ERR_THRESH(6)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .valid(valid),
        .a(a), .b(b), .fail(fail), .fail_cnt(fail_cnt), .sev(sev), .err_any(err_any)
    );

    xor_assert_monitor #(
        .WIDTH(8), .CHANNELS(4), .CNT_W(3), .WARN_THRESH(2), .ERR_THRESH(5)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .valid(valid),
        .a(a), .b(b), .fail(s_fail), .fail_cnt(s_fail_cnt), .sev(s_sev), .err_any(s_err_any)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic t_en, input logic [1:0] t_mode,
                                 input logic t_clr, input logic [3:0] t_valid,
                                 input logic [31:0] t_a, input logic [31:0] t_b);
        en    = t_en;
        mode  = t_mode;
        clr   = t_clr;
        valid = t_valid;
        a     = t_a;
        b     = t_b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_fail,
                               input logic [31:0] e_cnt, input logic [7:0] e_sev,
                               input logic e_err);
        checkOne({name, ".fail"},    32'(fail),    32'(e_fail));
        checkOne({name, ".cnt"},     fail_cnt,     e_cnt);
        checkOne({name, ".sev"},     32'(sev),     32'(e_sev));
        checkOne({name, ".err_any"}, 32'(err_any), 32'(e_err));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b0;
        mode   = 2'd0;
        clr    = 1'b0;
        valid  = '0;
        a      = '0;
        b      = '0;

        //                en    mode  clr   valid    a             b             fail     cnt           sev    err
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 4'b0001, 32'h0000005A, 32'h0000005A, 4'b0001, 32'h00000001, 8'h01, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 4'b0001, 32'h0000005A, 32'h0000005B, 4'b0000, 32'h00000001, 8'h01, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 4'b1111, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000001, 8'h01, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000001, 8'h01, 1'b0};
        vecs[4]  = '{1'b1, 2'd3, 1'b0, 4'b1111, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000001, 8'h01, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 4'b0100, 32'h00010000, 32'h00000000, 4'b0100, 32'h00010001, 8'h11, 1'b0};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 4'b0100, 32'h00010000, 32'h00000000, 4'b0100, 32'h00020001, 8'h11, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 4'b0100, 32'h00010000, 32'h00000000, 4'b0100, 32'h00030001, 8'h21, 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 4'b0100, 32'h00010000, 32'h00000000, 4'b0100, 32'h00040001, 8'h21, 1'b0};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 4'b0100, 32'h00010000, 32'h00000000, 4'b0100, 32'h00050001, 8'h21, 1'b0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 4'b0100, 32'h00010000, 32'h00000000, 4'b0100, 32'h00060001, 8'h31, 1'b1};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 4'b1111, 32'h01000703, 32'h00000000, 4'b0101, 32'h00070002, 8'h31, 1'b1};
        vecs[12] = '{1'b1, 2'd0, 1'b0, 4'b0010, 32'h00000000, 32'h00000000, 4'b0010, 32'h00070102, 8'h35, 1'b1};
        vecs[13] = '{1'b1, 2'd1, 1'b0, 4'b0010, 32'h00000000, 32'h00000000, 4'b0000, 32'h00070102, 8'h35, 1'b1};
        vecs[14] = '{1'b1, 2'd1, 1'b1, 4'b1000, 32'hFF000000, 32'h00000000, 4'b0000, 32'h00000000, 8'h00, 1'b0};
        vecs[15] = '{1'b1, 2'd1, 1'b0, 4'b1000, 32'hFF000000, 32'h00000000, 4'b1000, 32'h01000000, 8'h40, 1'b0};

        #1;
        checkOutput("reset", 4'b0000, 32'h0, 8'h00, 1'b0);
        #11;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].clr, vecs[i].valid, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_fail, vecs[i].exp_cnt,
                        vecs[i].exp_sev, vecs[i].exp_err);
        end

        // Drive ch1 into ERROR; ch3 already holds count 1 / INFO.
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 2'd1, 1'b0, 4'b0010, 32'h00000100, 32'h0);
            if (k == 3) checkOutput("ch1_warn", 4'b0010, 32'h01000300, 8'h48, 1'b0);
        end
        checkOutput("ch1_error", 4'b0010, 32'h01000600, 8'h4C, 1'b1);

        // Passing samples never lower count or severity.
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 2'd1, 1'b0, 4'b0010, 32'h0, 32'h0);
        checkOutput("ch1_sticky", 4'b0000, 32'h01000600, 8'h4C, 1'b1);

        applyStimulus(1'b0, 2'd1, 1'b0, 4'b1111, 32'hFFFFFFFF, 32'h0);
        checkOutput("en_gate", 4'b0000, 32'h01000600, 8'h4C, 1'b1);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        applyStimulus(1'b1, 2'd1, 1'b0, 4'b0010, 32'h00000100, 32'h0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 4'b0000, 32'h0, 8'h00, 1'b0);
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 2'd0, 1'b0, 4'b0001, 32'h0, 32'h0);
        checkOutput("post_rst", 4'b0001, 32'h00000001, 8'h01, 1'b0);

        // Saturation on the CNT_W=3 instance, then clr beating a failure.
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 2'd1, 1'b0, 4'b0001, 32'h00000001, 32'h0);
            checkOne($sformatf("sat_cnt%0d", k), 32'(s_fail_cnt[2:0]), (k > 7) ? 32'd7 : 32'(k));
            checkOne($sformatf("sat_fail%0d", k), 32'(s_fail[0]), 32'd1);
        end
        checkOne("sat_sev", 32'(s_sev[1:0]), 32'd3);
        checkOne("sat_err", 32'(s_err_any), 32'd1);

        applyStimulus(1'b1, 2'd1, 1'b1, 4'b0001, 32'h00000001, 32'h0);
        checkOne("clr_cnt",  32'(s_fail_cnt), 32'd0);
        checkOne("clr_sev",  32'(s_sev), 32'd0);
        checkOne("clr_fail", 32'(s_fail), 32'd0);
        checkOne("clr_err",  32'(s_err_any), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
